// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack into a small
// FIFO and presents them to decode via valid/ready; redirect flushes and re-steers.
// Optional feature macro: FETCH_PREDECODE_EN adds instr_is_branch_o (beq predecode).
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
`ifdef FETCH_PREDECODE_EN
    output logic        instr_is_branch_o,
`endif
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
`ifdef FETCH_PREDECODE_EN
        logic        is_branch;
`endif
    } entry_t;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        addr_q, addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push;
    logic               pop;
    logic               room;
    entry_t             mem_q [FIFO_DEPTH];
    entry_t             head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state logic: FIFO bookkeeping, PC update, fetch FSM and held fetch address
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = instr_valid_o && instr_ready_i;
        push     = (state_q == REQ) && imem_ack_i && !redirect_i;

        if (redirect_i) begin
            pc_d     = redirect_pc_i & 32'hFFFF_FFFC;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                pc_d     = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // A request only starts when a slot is free after this cycle's push/pop/flush
        room = (count_d < CNT_W'(FIFO_DEPTH));

        unique case (state_q)
            IDLE: begin
                if (room) state_d = REQ;
            end
            REQ: begin
                if (imem_ack_i)      state_d = room ? REQ : IDLE;
                else if (redirect_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (imem_ack_i) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        // The stale request keeps its address until the memory acks it
        addr_d = (state_d == DRAIN) ? addr_q : pc_d;
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Instruction buffer storage; entries are qualified by count so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q].pc   <= addr_q;
            mem_q[wr_ptr_q].word <= imem_rdata_i;
`ifdef FETCH_PREDECODE_EN
            mem_q[wr_ptr_q].is_branch <= (imem_rdata_i[31:26] == 6'b000100);
`endif
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign imem_req_o    = (state_q != IDLE);
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? head.word : 32'h0000_0000;
    assign instr_pc_o    = instr_valid_o ? head.pc   : 32'h0000_0000;
`ifdef FETCH_PREDECODE_EN
    assign instr_is_branch_o = instr_valid_o && head.is_branch;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: expected program-order stream is
// queued by the stimulus side and compared by a monitor on every decode pop.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_PREDECODE_EN
    logic        instr_is_branch;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
`ifdef FETCH_PREDECODE_EN
        .instr_is_branch_o (instr_is_branch),
`endif
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] next_exp = RESET_PC;
    logic [31:0] fetch_exp = RESET_PC;
    int          occ = 0;
    bit          draining = 0;
    bit          hold = 0;
    logic [31:0] hold_addr = 32'h0;
    int          cyc = 0;
    int          pops = 0;
    int          mode = 0;

    // Program image: address-hashed words, every other 16-byte block is a beq
    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
        if (a[4]) h[31:26] = 6'b000100;
        else if (h[31:26] == 6'b000100) h[31:26] = 6'b000000;
        return h;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: protocol-level model of occupancy, fetch address and consumed stream
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        logic [31:0] tgt;
        bit          pop;
        bit          acc;
        bit          push;
        if (!rst_n) begin
            exp_q.delete();
            next_exp  = RESET_PC;
            fetch_exp = RESET_PC;
            occ       = 0;
            draining  = 0;
            hold      = 0;
            cyc       = 0;
        end else begin
            check("valid_vs_occupancy", {31'd0, instr_valid}, {31'd0, occ != 0});
            if (!instr_valid) begin
                check("empty_instr", instr, 32'h0);
                check("empty_pc", instr_pc, 32'h0);
`ifdef FETCH_PREDECODE_EN
                check("empty_branch", {31'd0, instr_is_branch}, 32'h0);
`endif
            end
            if (cyc == 0) check("release_addr", imem_addr, RESET_PC);
            else check("req_vs_room", {31'd0, imem_req}, {31'd0, occ < DEPTH});
            if (mode == 1 && cyc >= 2) check("throughput", {31'd0, instr_valid}, 32'h1);
            if (imem_req) check("addr_align", {30'd0, imem_addr[1:0]}, 32'h0);
            if (hold) begin
                check("req_held", {31'd0, imem_req}, 32'h1);
                check("addr_held", imem_addr, hold_addr);
            end
            if (imem_req && !draining) check("fetch_addr", imem_addr, fetch_exp);

            pop = instr_valid && instr_ready;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e);
                    check("instr_word", instr, word_of(e));
`ifdef FETCH_PREDECODE_EN
                    check("is_branch", {31'd0, instr_is_branch},
                          {31'd0, word_of(e) >> 26 == 32'd4});
`endif
                end
                pops++;
            end

            acc  = imem_req && imem_ack;
            push = acc && !draining && !redirect;
            if (redirect) begin
                tgt       = redirect_pc & 32'hFFFF_FFFC;
                exp_q.delete();
                next_exp  = tgt;
                fetch_exp = tgt;
                occ       = 0;
                draining  = imem_req && !imem_ack;
            end else begin
                occ = occ + (push ? 1 : 0) - (pop ? 1 : 0);
                if (acc && !draining) fetch_exp = fetch_exp + 32'd4;
                if (acc) draining = 0;
            end
            hold      = imem_req && !imem_ack;
            hold_addr = imem_addr;
            cyc++;
        end
    end

    // One stimulus cycle: top up expected stream, then drive memory and decode sides
    task automatic step(input bit a, input bit r, input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_exp);
            next_exp = next_exp + 32'd4;
        end
        instr_ready = r;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = a && imem_req;
        imem_rdata  = draining ? 32'hDEADBEEF : word_of(imem_addr);
    endtask

    initial begin
        logic [31:0] rpc;
        repeat (3) @(posedge clk);
        #1;
        mode        = 1;
        instr_ready = 1'b1;
        rst_n       = 1'b1;

        // Continuous ack and ready
        repeat (30) step(1, 1, 0, 32'h0);
        mode = 0;

        // Decode stalled: fetch must stop with the buffer full, then resume cleanly
        repeat (10) step(1, 0, 0, 32'h0);
        repeat (10) step(1, 1, 0, 32'h0);

        // Redirect with a full buffer
        repeat (5) step(1, 0, 0, 32'h0);
        step(1, 0, 1, 32'h0000_0100);
        repeat (10) step(1, 1, 0, 32'h0);

        // Redirect with a request pending, late ack returns stale data
        repeat (2) step(0, 1, 0, 32'h0);
        step(0, 1, 1, 32'h0000_0200);
        repeat (3) step(0, 1, 0, 32'h0);
        repeat (8) step(1, 1, 0, 32'h0);

        // Unaligned redirect target and PC wrap at the top of the address space
        step(1, 1, 1, 32'h0000_0103);
        repeat (6) step(1, 1, 0, 32'h0);
        step(1, 1, 1, 32'hFFFF_FFF6);
        repeat (8) step(1, 1, 0, 32'h0);

        // Reset asserted with a word buffered and a request pending
        step(1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("reset_req_async", {31'd0, imem_req}, 32'h0);
        check("reset_valid_async", {31'd0, instr_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        imem_ack = 1'b1;   // late ack with no request must be ignored
        repeat (10) step(1, 1, 0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 4, rpc);
        end
        step(0, 0, 0, 32'h0);
        @(negedge clk);
        check("fetch_progress", {31'd0, pops >= 500}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
